pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
- Parametrised stage-control generator for the N-stage MIPS pipeline core.
- Holds the per-stage valid bits and drives every stage's enable and reset.
- Detects load-use hazards, applies branch flushes and memory-wait freezes, and implements debug halt/single-step.
- Sits inside the controller and replaces the fixed 5-stage stall/flush logic. Adds multi-cycle memory wait, a configurable branch-resolve stage, and stall/flush performance counters.

Parameters:
STAGES, 5, number of pipeline stages (>=4); stage 0=IF, 1=ID, 2=EXE
MEM_STAGE, 3, index of the memory-access stage (2 < MEM_STAGE < STAGES)
BR_STAGE, 2, stage where branches resolve (1 <= BR_STAGE < MEM_STAGE)
REG_AW, 5, register address width
CNT_W, 32, performance counter width

Ports:
clk  in  1  main clock
rst  in  1  reset, asynchronous, active-high
debug_en  in  1  1 = halt pipeline except on single steps
debug_step  in  1  step request, level signal, rising edge = one step
id_rs_addr  in  REG_AW  rs of the ID instruction
id_rt_addr  in  REG_AW  rt of the ID instruction
id_rs_used  in  1  ID instruction reads rs
id_rt_used  in  1  ID instruction reads rt
exe_mem_ren  in  1  EXE instruction is a load
exe_wb_wen  in  1  EXE instruction writes a register
exe_regw_addr  in  REG_AW  EXE destination register
br_taken  in  1  redirect request from BR_STAGE
mem_busy  in  1  memory stage not ready this cycle
stage_en  out  STAGES  per-stage register enable
stage_rst  out  STAGES  per-stage synchronous clear (bubble insert)
stage_valid  out  STAGES  registered valid bit of each stage
stall_cnt  out  CNT_W  saturating count of stall cycles
flush_cnt  out  CNT_W  saturating count of branch flushes

Behaviour:
- Reset (async, rst=1):
  - vld, stall_cnt, flush_cnt, the step-edge register and the FSM clear immediately; FSM goes to RUN.
  - stage_en=0, stage_rst=all ones, stage_valid=0.
  - First cycle after rst falls: normal advance, vld[0]<=1.
- Debug FSM:
  - States: RUN, HALT, STEP.
  - RUN -> HALT when debug_en=1.
  - HALT -> STEP on a debug_step rising edge (step_d register).
  - STEP -> HALT after exactly one cycle.
  - HALT or STEP -> RUN when debug_en=0.
  - adv = (state==RUN && !debug_en) || state==STEP.
  - !adv: stage_en=0, stage_rst=0, counters and vld hold.
- Qualified events:
  - lu = vld[1] & vld[2] & exe_mem_ren & exe_wb_wen & exe_regw_addr!=0 & ((id_rs_used & id_rs_addr==exe_regw_addr) | (id_rt_used & id_rt_addr==exe_regw_addr)).
  - bt = br_taken & vld[BR_STAGE].
  - mb = mem_busy & vld[MEM_STAGE].
- Priority when adv: mb > bt > lu > normal.
  - normal: all stage_en=1, stage_rst=0; vld[i]<=vld[i-1], vld[0]<=1.
  - mb: stages 0..MEM_STAGE hold (en=0, vld hold). Stage MEM_STAGE+1 gets a bubble (rst=1, vld<=0) if it exists; later stages advance. stall_cnt+1.
  - bt: stages 1..BR_STAGE get rst=1 and vld<=0; stage 0 en=1 (loads the redirect PC); stages above BR_STAGE advance. flush_cnt+1. A simultaneous lu is discarded: its consumer is flushed.
  - lu: stages 0..1 hold; stage 2 gets a bubble (rst=1, vld<=0); stages >2 advance. stall_cnt+1.
- mb spanning multiple cycles: stall_cnt increments every cycle. bt arriving during mb is not lost: it is re-evaluated, and taken on the first cycle mb drops.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Outputs stage_en and stage_rst are combinational from state, vld and inputs (zero cycles of latency). stage_valid is registered.
- Reset mid-stall or mid-step: everything clears at once and no residual step is pending.

Decomposition:
- Shared package/header (define.vh): FSM state encodings (RUN, HALT, STEP) and default parameter constants.
- Natural sub-module: pipeline_ctrl_dbg, containing the debug FSM and step-edge detector, output adv.
- Hazard qualification, priority and the valid shift stay in the top.

Test Plan:
1. Reset release with no events -> stage_valid walks 00001, 00011, … 11111 over 5 cycles; all stage_en=1.
2. lw $3 in EXE with ID using rt=$3 -> one cycle of stage_en[1:0]=0 and stage_rst[2]=1; stall_cnt 0->1; vld[2]=0 next cycle.
3. mem_busy high 3 cycles with vld[3]=1 -> stage_en[3:0]=0 for 3 cycles; stage_rst[4]=1 each cycle; stall_cnt=3.
4. br_taken and the load-use condition in the same cycle -> stage_rst[2:1]=11, stage_en[0]=1; flush_cnt=1; stall_cnt unchanged.
5. debug_en=1, then two debug_step pulses -> exactly 2 advance cycles; stage_en=0 otherwise; debug_en=0 resumes every cycle.
6. CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15. Assert rst during a stall -> all outputs clear the same cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - debug FSM encodings and default pipeline geometry
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam int DEF_STAGES    = 5;
  localparam int DEF_MEM_STAGE = 3;
  localparam int DEF_BR_STAGE  = 2;
  localparam int DEF_REG_AW    = 5;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/pipeline_ctrl_dbg.sv
// rtl/pipeline_ctrl_dbg.sv - debug halt/single-step FSM producing the advance qualifier
module pipeline_ctrl_dbg
  import pipeline_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic debug_en,
  input  logic debug_step,
  output logic adv
);

  logic [1:0] state_q, state_d;
  logic       step_q, step_d;
  logic       step_rise;

  assign step_d    = debug_step;
  assign step_rise = debug_step & ~step_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (debug_en) state_d = ST_HALT;
      ST_HALT: begin
        if (!debug_en)     state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_STEP: state_d = debug_en ? ST_HALT : ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // A step request only counts from HALT; a level held high never re-triggers.
  assign adv = ((state_q == ST_RUN) && !debug_en) || (state_q == ST_STEP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - per-stage enable/clear/valid generation with hazard priority and perf counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STAGES    = DEF_STAGES,
  parameter int MEM_STAGE = DEF_MEM_STAGE,
  parameter int BR_STAGE  = DEF_BR_STAGE,
  parameter int REG_AW    = DEF_REG_AW,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic              exe_mem_ren,
  input  logic              exe_wb_wen,
  input  logic [REG_AW-1:0] exe_regw_addr,
  input  logic              br_taken,
  input  logic              mem_busy,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_rst,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] vld_shift;
  logic [STAGES-1:0] en_c, rst_c;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_q, flush_d;
  logic              adv;
  logic              rs_hit, rt_hit;
  logic              lu, bt, mb;

  pipeline_ctrl_dbg u_dbg (
    .clk        (clk),
    .rst        (rst),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .adv        (adv)
  );

  assign rs_hit = id_rs_used & (id_rs_addr == exe_regw_addr);
  assign rt_hit = id_rt_used & (id_rt_addr == exe_regw_addr);

  assign lu = vld_q[1] & vld_q[2] & exe_mem_ren & exe_wb_wen &
              (exe_regw_addr != '0) & (rs_hit | rt_hit);
  assign bt = br_taken & vld_q[BR_STAGE];
  assign mb = mem_busy & vld_q[MEM_STAGE];

  assign vld_shift = {vld_q[STAGES-2:0], 1'b1};

  // Bubble stages are enabled so that the synchronous clear takes effect.
  always_comb begin
    en_c    = '0;
    rst_c   = '0;
    vld_d   = vld_q;
    stall_d = stall_q;
    flush_d = flush_q;
    if (adv) begin
      if (mb) begin
        for (int i = 0; i < STAGES; i++) begin
          if (i == MEM_STAGE + 1) begin
            en_c[i]  = 1'b1;
            rst_c[i] = 1'b1;
            vld_d[i] = 1'b0;
          end else if (i > MEM_STAGE + 1) begin
            en_c[i]  = 1'b1;
            vld_d[i] = vld_shift[i];
          end
        end
        if (~&stall_q) stall_d = stall_q + 1'b1;
      end else if (bt) begin
        for (int i = 0; i < STAGES; i++) begin
          en_c[i] = 1'b1;
          if (i >= 1 && i <= BR_STAGE) begin
            rst_c[i] = 1'b1;
            vld_d[i] = 1'b0;
          end else begin
            vld_d[i] = vld_shift[i];
          end
        end
        if (~&flush_q) flush_d = flush_q + 1'b1;
      end else if (lu) begin
        for (int i = 2; i < STAGES; i++) begin
          en_c[i] = 1'b1;
          if (i == 2) begin
            rst_c[i] = 1'b1;
            vld_d[i] = 1'b0;
          end else begin
            vld_d[i] = vld_shift[i];
          end
        end
        if (~&stall_q) stall_d = stall_q + 1'b1;
      end else begin
        en_c  = '1;
        vld_d = vld_shift;
      end
    end
  end

  assign stage_en    = rst ? '0 : en_c;
  assign stage_rst   = rst ? '1 : rst_c;
  assign stage_valid = vld_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      vld_q   <= vld_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

endmodule
